// File: rtl/inst_sram_if.sv
// Instruction SRAM bus interface.
// Groups the fetch channel (araddr/arvalid/arready, rdata/rresp/rvalid/rready)
// and the preload write port (we/waddr/wdata/wstrb).
//   master : fetch requester / preloader (drives requests, consumes responses)
//   slave  : the SRAM (accepts requests, produces responses)
interface inst_sram_if #(
  parameter int BITWIDTH = 32
);
  logic [BITWIDTH-1:0] araddr;
  logic                arvalid;
  logic                arready;
  logic [31:0]         rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;
  logic                we;
  logic [BITWIDTH-1:0] waddr;
  logic [31:0]         wdata;
  logic [3:0]          wstrb;

  modport master (
    output araddr, arvalid, rready, we, waddr, wdata, wstrb,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arvalid, rready, we, waddr, wdata, wstrb,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/inst_sram.sv
// Instruction SRAM with a single-outstanding fetch port and a byte-masked
// preload write port.
// Ports:
//   clk  - sole clock, all state updates on its rising edge
//   rst  - synchronous, active-high reset (control and response registers;
//          memory contents are kept)
//   bus  - inst_sram_if.slave: fetch request/response channel plus preload
// A fetch is accepted in IDLE, waits LATENCY cycles in WAIT, then presents a
// registered response in RESP until the consumer takes it.
// rresp: 00 OKAY, 10 misaligned address, 11 address outside the array.
module inst_sram #(
  parameter int                  BITWIDTH   = 32,
  parameter logic [BITWIDTH-1:0] ADDR_BASE  = 32'h80000000,
  parameter int                  DEPTH_LOG2 = 10,
  parameter int                  LATENCY    = 2   // 0..15, held in a 4-bit counter
) (
  input  logic         clk,
  input  logic         rst,
  inst_sram_if.slave   bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [1:0] RESP_OKAY     = 2'b00;
  localparam logic [1:0] RESP_MISALIGN = 2'b10;
  localparam logic [1:0] RESP_RANGE    = 2'b11;

  // Counter reload value; with LATENCY=0 the WAIT state is never entered.
  localparam logic [3:0] LAT_M1 = 4'((LATENCY > 0) ? (LATENCY - 1) : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // Classify a byte address. Misalignment wins over range. The offset from
  // ADDR_BASE is taken modulo 2^BITWIDTH, so addresses below the base wrap to
  // large offsets and fail the range test along with addresses above it.
  function automatic logic [1:0] addr_check(input logic [BITWIDTH-1:0] a);
    logic [BITWIDTH-1:0] off;
    off = a - ADDR_BASE;
    if (a[1:0] != 2'b00) begin
      return RESP_MISALIGN;
    end else if ((off >> (DEPTH_LOG2 + 2)) != '0) begin
      return RESP_RANGE;
    end else begin
      return RESP_OKAY;
    end
  endfunction

  function automatic logic [DEPTH_LOG2-1:0] word_index(input logic [BITWIDTH-1:0] a);
    logic [BITWIDTH-1:0] off;
    off = a - ADDR_BASE;
    return DEPTH_LOG2'(off >> 2);
  endfunction

  logic [31:0] mem [DEPTH];

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [BITWIDTH-1:0] addr_q, addr_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [1:0]          rresp_q, rresp_d;

  logic                load_resp;
  logic [BITWIDTH-1:0] rd_addr;
  logic [1:0]          rd_resp;
  logic [31:0]         rd_word;
  logic                wr_en;

  // Preload write: dropped under reset and for any address that would not
  // read back as OKAY.
  assign wr_en = bus.we && !rst && (addr_check(bus.waddr) == RESP_OKAY);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.wstrb[i]) begin
          mem[word_index(bus.waddr)][8*i +: 8] <= bus.wdata[8*i +: 8];
        end
      end
    end
  end

  // With LATENCY=0 the response is loaded at the handshake edge itself, so the
  // lookup must use the live request address rather than the latched one.
  // The array is read before the edge, so a same-edge preload write to the
  // same word is not visible in this response.
  always_comb begin
    rd_addr = (state_q == S_IDLE) ? bus.araddr : addr_q;
    rd_resp = addr_check(rd_addr);
    rd_word = mem[word_index(rd_addr)];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    load_resp = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.arvalid) begin
          addr_d = bus.araddr;
          if (LATENCY == 0) begin
            state_d   = S_RESP;
            load_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d   = S_RESP;
          load_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        // Returning to IDLE only; the next request is taken one cycle later.
        if (bus.rready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (load_resp) begin
      rresp_d = rd_resp;
      rdata_d = (rd_resp == RESP_OKAY) ? rd_word : 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      rresp_q <= RESP_OKAY;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
    end
    addr_q <= addr_d;
  end

  // arready is gated by rst so that no request is seen as accepted while the
  // block is being reset.
  assign bus.arready = (state_q == S_IDLE) && !rst;
  assign bus.rvalid  = (state_q == S_RESP);
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;

endmodule

// File: tb/tb_inst_sram.sv
module tb_inst_sram;

  localparam logic [31:0]     BASE = 32'h80000000;
  localparam int              NW   = 1024;
  localparam longint unsigned LO   = 64'h0000_0000_8000_0000;
  localparam longint unsigned HI   = LO + 64'd4096;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int total = 0;
  int bad   = 0;

  inst_sram_if #(.BITWIDTH(32)) b2 ();
  inst_sram_if #(.BITWIDTH(32)) b0 ();

  inst_sram #(.BITWIDTH(32), .ADDR_BASE(32'h80000000), .DEPTH_LOG2(10), .LATENCY(2))
    dut (.clk(clk), .rst(rst), .bus(b2.slave));

  inst_sram #(.BITWIDTH(32), .ADDR_BASE(32'h80000000), .DEPTH_LOG2(10), .LATENCY(0))
    dut0 (.clk(clk), .rst(rst), .bus(b0.slave));

  always #5 clk = ~clk;

  // Reference memory: one word per entry, shared by both instances since they
  // receive identical preload traffic.
  logic [31:0] mdl [NW];

  function automatic logic [1:0] m_resp(input logic [31:0] a);
    longint unsigned ua;
    ua = 64'(a);
    if ((a % 4) != 0) return 2'b10;
    if (ua < LO || ua >= HI) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [31:0] m_data(input logic [31:0] a);
    if (m_resp(a) != 2'b00) return 32'd0;
    return mdl[(a - BASE) / 4];
  endfunction

  task automatic m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx;
    if (m_resp(a) != 2'b00) return;
    idx = int'((a - BASE) / 4);
    for (int i = 0; i < 4; i++)
      if (s[i]) mdl[idx][8*i +: 8] = d[8*i +: 8];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    b2.we = 1'b1; b2.waddr = a; b2.wdata = d; b2.wstrb = s;
    b0.we = 1'b1; b0.waddr = a; b0.wdata = d; b0.wstrb = s;
  endtask

  task automatic clr_w();
    b2.we = 1'b0;
    b0.we = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic was_rst;
    was_rst = rst;
    set_w(a, d, s);
    tick();
    clr_w();
    if (!was_rst) m_write(a, d, s);
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 4))
      0, 1:    return BASE + 32'($urandom_range(0, NW - 1)) * 4;
      2:       return BASE + 32'($urandom_range(0, NW - 1)) * 4 + 32'($urandom_range(1, 3));
      3:       return BASE + 32'h1000 + 32'($urandom_range(0, 63)) * 4;
      default: return $urandom;
    endcase
  endfunction

  // One fetch on the LATENCY=2 instance: checks acceptance, response timing,
  // response content, hold-while-stalled behaviour and the return to IDLE.
  // With collide set, a preload write to the same address lands on the edge
  // that loads the response, which must still carry the old word.
  task automatic rd2(input logic [31:0] a, input int hold, input bit collide);
    logic [31:0] ed;
    logic [1:0]  er;
    int          n;
    bit          wrote;
    total++;
    if (b2.arready !== 1'b1) begin
      bad++; $display("FAIL rd2_arready_idle addr=%h got=%b exp=1", a, b2.arready);
    end
    ed = m_data(a);
    er = m_resp(a);
    b2.araddr  = a;
    b2.arvalid = 1'b1;
    tick();
    b2.arvalid = 1'b0;
    b2.araddr  = $urandom;
    n = 1;
    while (b2.rvalid !== 1'b1 && n < 40) begin
      wrote = 1'b0;
      if (collide && n == 2) begin
        set_w(a, ~ed, 4'hF);
        wrote = 1'b1;
      end
      tick();
      if (wrote) begin
        clr_w();
        m_write(a, ~ed, 4'hF);
      end
      n++;
    end
    total++;
    if (n != 3) begin
      bad++; $display("FAIL rd2_latency addr=%h got=%0d exp=3", a, n);
    end
    total++;
    if (b2.rdata !== ed) begin
      bad++; $display("FAIL rd2_rdata addr=%h got=%h exp=%h", a, b2.rdata, ed);
    end
    total++;
    if (b2.rresp !== er) begin
      bad++; $display("FAIL rd2_rresp addr=%h got=%b exp=%b", a, b2.rresp, er);
    end
    for (int k = 0; k < hold; k++) begin
      b2.arvalid = 1'b1;
      b2.araddr  = BASE + 32'($urandom_range(0, NW - 1)) * 4;
      tick();
      total++;
      if (b2.rvalid !== 1'b1 || b2.rdata !== ed || b2.rresp !== er || b2.arready !== 1'b0) begin
        bad++;
        $display("FAIL rd2_hold addr=%h k=%0d got v=%b d=%h r=%b ar=%b exp v=1 d=%h r=%b ar=0",
                 a, k, b2.rvalid, b2.rdata, b2.rresp, b2.arready, ed, er);
      end
    end
    b2.arvalid = 1'b0;
    b2.rready  = 1'b1;
    tick();
    b2.rready  = 1'b0;
    total++;
    if (b2.rvalid !== 1'b0 || b2.arready !== 1'b1) begin
      bad++;
      $display("FAIL rd2_release addr=%h got v=%b ar=%b exp v=0 ar=1", a, b2.rvalid, b2.arready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if (b2.arready !== 1'b0 || b0.arready !== 1'b0) begin
      bad++; $display("FAIL reset_arready got=%b/%b exp=0/0", b2.arready, b0.arready);
    end
    total++;
    if (b2.rvalid !== 1'b0 || b0.rvalid !== 1'b0) begin
      bad++; $display("FAIL reset_rvalid got=%b/%b exp=0/0", b2.rvalid, b0.rvalid);
    end
    total++;
    if (b2.rdata !== 32'd0 || b2.rresp !== 2'b00) begin
      bad++; $display("FAIL reset_resp got d=%h r=%b exp d=0 r=00", b2.rdata, b2.rresp);
    end
    rst = 1'b0;
    #1;
    total++;
    if (b2.arready !== 1'b1 || b0.arready !== 1'b1) begin
      bad++; $display("FAIL reset_release_arready got=%b/%b exp=1/1", b2.arready, b0.arready);
    end
  endtask

  task automatic test_preload_all();
    for (int i = 0; i < NW; i++)
      wr(BASE + 32'(i) * 4, $urandom, 4'hF);
  endtask

  task automatic test_basic();
    wr(BASE, 32'h00000413, 4'hF);
    rd2(BASE, 0, 1'b0);
    rd2(BASE, 5, 1'b0);
    wr(BASE, 32'h0000AB00, 4'b0010);
    total++;
    if (m_data(BASE) !== 32'h0000AB13) begin
      bad++; $display("FAIL model_strobe got=%h exp=0000ab13", m_data(BASE));
    end
    rd2(BASE, 1, 1'b0);
  endtask

  task automatic test_errors();
    logic [31:0] addrs [8];
    addrs = '{32'h80000002, 32'h7FFFFFFC, 32'h80001000, 32'h80000FFC,
              32'h80000FFD, 32'h00000000, 32'hFFFFFFFC, 32'h80000001};
    for (int i = 0; i < 8; i++) rd2(addrs[i], 1, 1'b0);
    // Writes to bad addresses must not alias onto any stored word.
    wr(32'h80001000, 32'hDEADBEEF, 4'hF);
    wr(32'h80000006, 32'hDEADBEEF, 4'hF);
    wr(32'h7FFFFFFC, 32'hDEADBEEF, 4'hF);
    rd2(BASE, 0, 1'b0);
    rd2(BASE + 4, 0, 1'b0);
    rd2(BASE + 32'hFFC, 0, 1'b0);
  endtask

  task automatic test_collide();
    rd2(BASE + 36, 0, 1'b1);
    rd2(BASE + 36, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 2) == 0)
        wr(rand_addr(), $urandom, 4'($urandom_range(0, 15)));
      rd2(rand_addr(), $urandom_range(0, 3), $urandom_range(0, 3) == 0);
    end
  endtask

  task automatic test_abort();
    logic [31:0] a;
    int          seen;
    a = BASE + 28;
    b2.araddr  = a;
    b2.arvalid = 1'b1;
    tick();
    b2.arvalid = 1'b0;
    rst = 1'b1;
    wr(a, ~mdl[7], 4'hF);
    tick();
    rst = 1'b0;
    #1;
    total++;
    if (b2.arready !== 1'b1) begin
      bad++; $display("FAIL abort_arready got=%b exp=1", b2.arready);
    end
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      if (b2.rvalid === 1'b1) seen++;
      tick();
    end
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL abort_no_rvalid got=%0d exp=0", seen);
    end
    rd2(a, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, ed;
    logic [1:0]  er;
    b0.rready  = 1'b1;
    b0.arvalid = 1'b1;
    for (int t = 0; t < 10; t++) begin
      a  = (t % 3 == 2) ? rand_addr() : BASE + 32'($urandom_range(0, NW - 1)) * 4;
      ed = m_data(a);
      er = m_resp(a);
      total++;
      if (b0.arready !== 1'b1 || b0.rvalid !== 1'b0) begin
        bad++; $display("FAIL b2b_accept t=%0d got ar=%b v=%b exp ar=1 v=0", t, b0.arready, b0.rvalid);
      end
      b0.araddr = a;
      tick();
      b0.araddr = $urandom;
      total++;
      if (b0.rvalid !== 1'b1 || b0.arready !== 1'b0 || b0.rdata !== ed || b0.rresp !== er) begin
        bad++;
        $display("FAIL b2b_resp t=%0d addr=%h got v=%b ar=%b d=%h r=%b exp v=1 ar=0 d=%h r=%b",
                 t, a, b0.rvalid, b0.arready, b0.rdata, b0.rresp, ed, er);
      end
      tick();
    end
    b0.arvalid = 1'b0;
    tick();
    total++;
    if (b0.rvalid !== 1'b0 || b0.arready !== 1'b1) begin
      bad++; $display("FAIL b2b_idle got v=%b ar=%b exp v=0 ar=1", b0.rvalid, b0.arready);
    end
  endtask

  initial begin
    b2.araddr = '0; b2.arvalid = 1'b0; b2.rready = 1'b0;
    b2.we = 1'b0; b2.waddr = '0; b2.wdata = '0; b2.wstrb = '0;
    b0.araddr = '0; b0.arvalid = 1'b0; b0.rready = 1'b1;
    b0.we = 1'b0; b0.waddr = '0; b0.wdata = '0; b0.wstrb = '0;
    for (int i = 0; i < NW; i++) mdl[i] = '0;

    test_reset();
    test_preload_all();
    test_basic();
    test_errors();
    test_collide();
    test_abort();
    test_random();
    test_back_to_back();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/inst_sram.md
INST_SRAM -- requirements
Module: inst_sram

Interface
REQ-001 The block SHALL have parameter BITWIDTH, default 32, as the address and data width.
REQ-002 The block SHALL have parameter ADDR_BASE, default 32'h80000000, as the byte address of word 0.
REQ-003 The block SHALL have parameter DEPTH_LOG2, default 10, giving 2^DEPTH_LOG2 words of storage.
REQ-004 The block SHALL have parameter LATENCY, default 2, range 0..15, as the number of extra wait cycles.
REQ-005 clk  in  1  sole clock; all state updates on posedge clk.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 araddr  in  BITWIDTH  fetch address (PC).
REQ-008 arvalid  in  1  fetch request valid.
REQ-009 arready  out  1  block can accept a request.
REQ-010 rdata  out  32  instruction word.
REQ-011 rresp  out  2  00 OKAY, 10 misaligned, 11 out of range.
REQ-012 rvalid  out  1  response valid.
REQ-013 rready  in  1  consumer accepts the response.
REQ-014 we  in  1  preload write enable.
REQ-015 waddr  in  BITWIDTH  preload byte address.
REQ-016 wdata  in  32  preload data.
REQ-017 wstrb  in  4  preload byte enables; bit i writes byte i.

Function
REQ-018 The block SHALL implement states IDLE, WAIT and RESP.
REQ-019 arready SHALL be 1 only in IDLE; rvalid SHALL be 1 only in RESP.
REQ-020 A handshake occurs in a cycle with arvalid=1 and arready=1; araddr SHALL be latched at that edge.
REQ-021 On handshake, IDLE->RESP if LATENCY=0; otherwise IDLE->WAIT with the wait counter loaded to LATENCY-1.
REQ-022 In WAIT, counter=0 -> RESP at the next edge; otherwise the counter decrements.
REQ-023 The first cycle with rvalid=1 SHALL be cycle H+1+LATENCY, where H is the handshake cycle.
REQ-024 rdata and rresp SHALL be registered on the edge entering RESP and held stable while rvalid=1 and rready=0.
REQ-025 In RESP, rvalid=1 and rready=1 -> IDLE at the next edge; no new request is accepted in the same cycle.
REQ-026 Only one outstanding request is allowed; arvalid in WAIT or RESP SHALL be ignored (arready=0).
REQ-027 If araddr[1:0]!=0, the response SHALL be rresp=10 and rdata=0.
REQ-028 If the address is aligned but outside [ADDR_BASE, ADDR_BASE+4*2^DEPTH_LOG2), the response SHALL be rresp=11 and rdata=0.
REQ-029 The misaligned check SHALL take precedence over the out-of-range check.
REQ-030 Otherwise rresp=00 and rdata = mem[(addr-ADDR_BASE)>>2].
REQ-031 Preload: if we=1 and waddr is aligned and in range, bytes selected by wstrb SHALL be written at the edge in any state.
REQ-032 Preload writes to misaligned or out-of-range addresses SHALL be dropped silently.
REQ-033 If a preload write and the RESP-entry read hit the same word at the same edge, the read SHALL return the old data.

Reset
REQ-034 While rst=1 at an edge: state becomes IDLE, rvalid=0, rdata=0, rresp=00, counter=0.
REQ-035 arready SHALL be 0 while rst=1 and 1 in the first cycle after rst deasserts.
REQ-036 Reset mid-transaction SHALL abort the request; no response is issued for it.
REQ-037 Memory contents SHALL NOT be reset.
REQ-038 A preload write with rst=1 SHALL be ignored.

Verification
REQ-039 Preload 80000000->00000413, LATENCY=2; handshake araddr=80000000 in cycle H -> rvalid=1 from H+3, rdata=00000413, rresp=00.
REQ-040 With rready=0 for 5 cycles after rvalid rises -> rvalid, rdata and rresp held; arready=0; a second arvalid is ignored.
REQ-041 araddr=80000002 -> rresp=10, rdata=0; araddr=7FFFFFFC -> rresp=11; araddr=80001000 (DEPTH_LOG2=10) -> rresp=11.
REQ-042 LATENCY=0, rready tied to 1, back-to-back requests -> rvalid in H+1, arready=1 in H+2, one transaction every 2 cycles.
REQ-043 Assert rst in a WAIT cycle -> rvalid never rises for that request; arready=1 in the cycle after rst deasserts; memory is retained.
REQ-044 wstrb=0010, wdata=0000AB00 written to 80000000 holding 00000413 -> subsequent read returns 0000AB13.
